// File: rtl/dense_seq_pkg.sv
// Shared constants for the dense-layer sequencer: FSM state codes,
// the clogb2 width helper and the default-configuration derived sizes.
package dense_seq_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 3'd1;
  localparam logic [ST_W-1:0] ST_ADDR = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT = 3'd3;
  localparam logic [ST_W-1:0] ST_ACC  = 3'd4;
  localparam logic [ST_W-1:0] ST_BIAS = 3'd5;
  localparam logic [ST_W-1:0] ST_EMIT = 3'd6;
  localparam logic [ST_W-1:0] ST_DONE = 3'd7;

  // Bits needed to hold the value v; never less than 1.
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_H      = 2;
  localparam int unsigned DEF_DEPTH  = 64;
  localparam int unsigned DEF_BIAS   = 128;
  localparam int unsigned DEF_ONCE   = 64;
  localparam int unsigned DEF_RD_LAT = 1;

  localparam int unsigned GPR    = DEF_DEPTH / DEF_ONCE;
  localparam int unsigned NCHUNK = DEF_H * GPR;
  localparam int unsigned KA_W   = clogb2(DEF_BIAS * NCHUNK - 1);

endpackage

// File: rtl/dense_seq_lat_pipe.sv
// RD_LAT-deep shift register that aligns the accumulator strobes and
// operand selects with kernel data returning from the BRAM.
module dense_seq_lat_pipe
  import dense_seq_pkg::*;
#(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [LAT];

  // Shift issue-side values one stage per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[LAT-1];

endmodule

// File: rtl/dense_layer_sequencer.sv
// Control FSM for one dense layer: loads H input rows, then walks BIAS
// neurons x NCHUNK kernel chunks driving BRAM addresses and accumulator
// strobes, and hands each neuron downstream over valid/ready.
// Optional DENSE_SEQ_PREFETCH_EN: back-to-back kernel issue with the
// accumulator controls delayed RD_LAT cycles through dense_seq_lat_pipe.
module dense_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter  int unsigned H      = DEF_H,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  parameter  int unsigned BIAS   = DEF_BIAS,
  parameter  int unsigned ONCE   = DEF_ONCE,
  parameter  int unsigned RD_LAT = DEF_RD_LAT,
  localparam int unsigned GRPS   = DEPTH / ONCE,
  localparam int unsigned CHUNKS = H * GRPS,
  localparam int unsigned RW     = clogb2(H - 1),
  localparam int unsigned GW     = clogb2(GRPS - 1),
  localparam int unsigned KAW    = clogb2(BIAS * CHUNKS - 1),
  localparam int unsigned BW     = clogb2(BIAS - 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           row_we,
  output logic [RW-1:0]  row_waddr,
  output logic [RW-1:0]  row_sel,
  output logic [GW-1:0]  grp_sel,
  output logic           kmem_en,
  output logic [KAW-1:0] kernel_addr,
  output logic [BW-1:0]  bias_addr,
  output logic           acc_en,
  output logic           acc_clr,
  output logic           bias_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BW-1:0]  out_idx,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = clogb2(CHUNKS - 1);
  localparam int unsigned WW = clogb2(RD_LAT - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [RW-1:0]   ld_q, ld_d;
  logic [BW-1:0]   b_q, b_d;
  logic [CW-1:0]   c_q, c_d;
  logic [WW-1:0]   w_q, w_d;
  logic [KAW-1:0]  kernel_addr_q, kernel_addr_d;
  logic            in_ready_q, kmem_en_q, bias_en_q, out_valid_q, busy_q, done_q;

  // Next-state and counter updates.
  always_comb begin
    state_d       = state_q;
    ld_d          = ld_q;
    b_d           = b_q;
    c_d           = c_q;
    w_d           = w_q;
    case (state_q)
      ST_IDLE: begin
        ld_d = '0;
        b_d  = '0;
        c_d  = '0;
        w_d  = '0;
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (ld_q == RW'(H - 1)) begin
            ld_d    = '0;
            b_d     = '0;
            c_d     = '0;
            w_d     = '0;
            state_d = ST_ADDR;
          end else begin
            ld_d = ld_q + RW'(1);
          end
        end
      end
`ifdef DENSE_SEQ_PREFETCH_EN
      // One chunk address per cycle, then drain the read latency in ACC.
      ST_ADDR: begin
        if (c_q == CW'(CHUNKS - 1)) begin
          w_d     = '0;
          state_d = ST_ACC;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      ST_ACC: begin
        if (w_q == WW'(RD_LAT - 1)) begin
          w_d     = '0;
          state_d = ST_BIAS;
        end else begin
          w_d = w_q + WW'(1);
        end
      end
`else
      ST_ADDR: begin
        w_d     = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_q == WW'(RD_LAT - 1)) begin
          w_d     = '0;
          state_d = ST_ACC;
        end else begin
          w_d = w_q + WW'(1);
        end
      end
      ST_ACC: begin
        if (c_q == CW'(CHUNKS - 1)) begin
          state_d = ST_BIAS;
        end else begin
          c_d     = c_q + CW'(1);
          state_d = ST_ADDR;
        end
      end
`endif
      ST_BIAS: state_d = ST_EMIT;
      ST_EMIT: begin
        if (out_ready) begin
          c_d = '0;
          if (b_q == BW'(BIAS - 1)) begin
            b_d     = '0;
            state_d = ST_DONE;
          end else begin
            b_d     = b_q + BW'(1);
            state_d = ST_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    kernel_addr_d = KAW'(b_d) * KAW'(CHUNKS) + KAW'(c_d);
  end

  // State, counters and state-decoded outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      ld_q          <= '0;
      b_q           <= '0;
      c_q           <= '0;
      w_q           <= '0;
      kernel_addr_q <= '0;
      in_ready_q    <= 1'b0;
      kmem_en_q     <= 1'b0;
      bias_en_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ld_q          <= ld_d;
      b_q           <= b_d;
      c_q           <= c_d;
      w_q           <= w_d;
      kernel_addr_q <= kernel_addr_d;
      in_ready_q    <= (state_d == ST_LOAD);
      kmem_en_q     <= (state_d == ST_ADDR);
      bias_en_q     <= (state_d == ST_BIAS);
      out_valid_q   <= (state_d == ST_EMIT);
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
    end
  end

`ifdef DENSE_SEQ_PREFETCH_EN
  localparam int unsigned PW = 2 + RW + GW;
  logic [PW-1:0] iss_c;
  logic [PW-1:0] lat_q;

  // Accumulator controls for the chunk being addressed this cycle.
  always_comb begin
    iss_c = {(state_q == ST_ADDR),
             (state_q == ST_ADDR) && (c_q == '0),
             RW'(32'(c_q) / GRPS),
             GW'(32'(c_q) % GRPS)};
  end

  dense_seq_lat_pipe #(
    .LAT (RD_LAT),
    .W   (PW)
  ) u_lat_pipe (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (iss_c),
    .q_o  (lat_q)
  );

  assign {acc_en, acc_clr, row_sel, grp_sel} = lat_q;
`else
  logic          acc_en_q, acc_clr_q;
  logic [RW-1:0] row_sel_q;
  logic [GW-1:0] grp_sel_q;

  // Accumulator controls and operand selects, stable from ADDR to ACC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      row_sel_q <= '0;
      grp_sel_q <= '0;
    end else begin
      acc_en_q  <= (state_d == ST_ACC);
      acc_clr_q <= (state_d == ST_ACC) && (c_d == '0);
      row_sel_q <= RW'(32'(c_d) / GRPS);
      grp_sel_q <= GW'(32'(c_d) % GRPS);
    end
  end

  assign acc_en  = acc_en_q;
  assign acc_clr = acc_clr_q;
  assign row_sel = row_sel_q;
  assign grp_sel = grp_sel_q;
`endif

  assign in_ready    = in_ready_q;
  assign row_we      = in_valid & in_ready_q;
  assign row_waddr   = ld_q;
  assign kmem_en     = kmem_en_q;
  assign kernel_addr = kernel_addr_q;
  assign bias_addr   = b_q;
  assign bias_en     = bias_en_q;
  assign out_valid   = out_valid_q;
  assign out_idx     = b_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
